// File: rtl/sfi_resp_if.sv
// rtl/sfi_resp_if.sv - request/response channel bundle for the SFI memory responder
interface sfi_resp_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [63:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_fault;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_fault
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_fault
    );
endinterface

// File: rtl/sfi_resp.sv
// rtl/sfi_resp.sv - sandboxed word-memory responder; optional sticky lockout via SFI_RESP_LOCK_EN
module sfi_resp #(
    parameter logic [31:0] SANDBOX_TAG = 32'hA2199872,
    parameter int          DEPTH_LOG2  = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    sfi_resp_if.slave    bus,
    output logic [7:0]   fault_cnt,
    output logic         locked
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

    state_t                r_state;
    state_t                w_next;
    logic                  r_we;
    logic [DEPTH_LOG2-1:0] r_idx;
    logic [31:0]           r_wdata;
    logic                  r_legal;
    logic [31:0]           r_rdata;
    logic                  r_fault;
    logic [7:0]            r_fault_cnt;
    logic [31:0]           r_mem [DEPTH];

    logic w_accept;
    logic w_addr_legal;
    logic w_ok;

    assign w_addr_legal = (bus.req_addr[63:32] == SANDBOX_TAG)
                       && (bus.req_addr[31:DEPTH_LOG2+2] == '0)
                       && (bus.req_addr[1:0] == 2'b00);

    assign w_accept = (r_state == S_IDLE) && bus.req_valid;

`ifdef SFI_RESP_LOCK_EN
    logic r_locked;

    // Lock is sampled at ACCESS so the very request that faults is the one that arms it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_locked <= 1'b0;
        else if (r_state == S_ACCESS && !w_ok)
            r_locked <= 1'b1;
    end

    assign w_ok   = r_legal && !r_locked;
    assign locked = r_locked;
`else
    assign w_ok   = r_legal;
    assign locked = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_accept) w_next = S_ACCESS;
            S_ACCESS: w_next = S_RESP;
            S_RESP:   if (bus.rsp_ready) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we        <= 1'b0;
            r_idx       <= '0;
            r_wdata     <= '0;
            r_legal     <= 1'b0;
            r_rdata     <= '0;
            r_fault     <= 1'b0;
            r_fault_cnt <= '0;
            for (int i = 0; i < DEPTH; i++)
                r_mem[i] <= '0;
        end else begin
            if (w_accept) begin
                r_we    <= bus.req_we;
                r_idx   <= bus.req_addr[DEPTH_LOG2+1:2];
                r_wdata <= bus.req_wdata;
                r_legal <= w_addr_legal;
            end
            if (r_state == S_ACCESS) begin
                if (w_ok) begin
                    r_fault <= 1'b0;
                    if (r_we) begin
                        r_mem[r_idx] <= r_wdata;
                        r_rdata      <= '0;
                    end else begin
                        r_rdata <= r_mem[r_idx];
                    end
                end else begin
                    r_rdata <= '0;
                    r_fault <= 1'b1;
                    if (r_fault_cnt != 8'hFF)
                        r_fault_cnt <= r_fault_cnt + 8'd1;
                end
            end
        end
    end

    assign bus.req_ready = (r_state == S_IDLE);
    assign bus.rsp_valid = (r_state == S_RESP);
    assign bus.rsp_rdata = r_rdata;
    assign bus.rsp_fault = r_fault;
    assign fault_cnt     = r_fault_cnt;
endmodule

// File: tb/tb_sfi_resp.sv
// tb/tb_sfi_resp.sv - directed self-checking bench for sfi_resp
module tb_sfi_resp;
    logic       clk;
    logic       rst_n;
    logic [7:0] fault_cnt;
    logic       locked;

    sfi_resp_if bus ();

    sfi_resp #(.SANDBOX_TAG(32'hA2199872), .DEPTH_LOG2(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus.slave),
        .fault_cnt (fault_cnt),
        .locked    (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef SFI_RESP_LOCK_EN
    localparam bit LOCK_MODE = 1'b1;
`else
    localparam bit LOCK_MODE = 1'b0;
`endif

    int         n_cmp = 0;
    int         n_mis = 0;
    int         exp_cnt = 0;
    bit         model_locked = 1'b0;
    int         lat;
    logic [31:0] got_rdata;
    logic        got_fault;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Presents one request and returns #1 after the edge where rsp_valid is first seen.
    task automatic issue(input logic we, input logic [63:0] addr, input logic [31:0] wdata,
                         output int latency);
        int n;
        @(negedge clk);
        n = 0;
        while (!bus.req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        latency = 1;
        n = 0;
        while (!bus.rsp_valid && n < 20) begin
            @(posedge clk);
            #1;
            latency++;
            n++;
        end
        if (!bus.rsp_valid) latency = 99;
    endtask

    task automatic xact(input string tag, input logic we, input logic [63:0] addr,
                        input logic [31:0] wdata, input bit legal,
                        input logic [31:0] exp_rdata, input bit chk_en);
        bit eff_legal;
        int l;
        eff_legal = legal && !model_locked;
        bus.rsp_ready = 1'b1;
        issue(we, addr, wdata, l);
        if (!eff_legal) begin
            if (exp_cnt < 255) exp_cnt++;
            if (LOCK_MODE) model_locked = 1'b1;
        end
        if (chk_en) begin
            chk({tag, "_lat"},   64'(l),              64'd2);
            chk({tag, "_rdata"}, {32'd0, bus.rsp_rdata},
                {32'd0, (eff_legal && !we) ? exp_rdata : 32'd0});
            chk({tag, "_fault"}, {63'd0, bus.rsp_fault}, {63'd0, !eff_legal});
            chk({tag, "_cnt"},   {56'd0, fault_cnt},  64'(exp_cnt));
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_req_ready", {63'd0, bus.req_ready}, 64'd1);
        chk("rst_rsp_valid", {63'd0, bus.rsp_valid}, 64'd0);
        chk("rst_rdata",     {32'd0, bus.rsp_rdata}, 64'd0);
        chk("rst_fault",     {63'd0, bus.rsp_fault}, 64'd0);
        chk("rst_cnt",       {56'd0, fault_cnt},     64'd0);
        chk("rst_locked",    {63'd0, locked},        64'd0);

        xact("wr_w1",   1'b1, 64'hA219987200000004, 32'hDEADBEEF, 1'b1, 32'h0,        1'b1);
        xact("rd_w1",   1'b0, 64'hA219987200000004, 32'h0,        1'b1, 32'hDEADBEEF, 1'b1);
        xact("rd_tag",  1'b0, 64'hBAD0ADD012345678, 32'h0,        1'b0, 32'h0,        1'b1);
        xact("rd_w1b",  1'b0, 64'hA219987200000004, 32'h0,        1'b1, 32'hDEADBEEF, 1'b1);
        xact("wr_oor",  1'b1, 64'hA219987200000040, 32'h12345678, 1'b0, 32'h0,        1'b1);
        xact("rd_mis",  1'b0, 64'hA219987200000002, 32'h0,        1'b0, 32'h0,        1'b1);
        xact("wr_btag", 1'b1, 64'h1219987200000004, 32'hCAFEF00D, 1'b0, 32'h0,        1'b1);
        xact("rd_w0",   1'b0, 64'hA219987200000000, 32'h0,        1'b1, 32'h0,        1'b1);
        xact("rd_w1c",  1'b0, 64'hA219987200000004, 32'h0,        1'b1, 32'hDEADBEEF, 1'b1);

        // Backpressure: response must hold steady and no new request may be taken.
        bus.rsp_ready = 1'b0;
        issue(1'b0, 64'hA219987200000004, 32'h0, lat);
        chk("bp_lat", 64'(lat), 64'd2);
        bus.req_valid = 1'b1;
        bus.req_addr  = 64'hA219987200000000;
        for (int i = 0; i < 5; i++) begin
            chk("bp_hold", {bus.rsp_valid, bus.req_ready, bus.rsp_fault, bus.rsp_rdata},
                {1'b1, 1'b0, model_locked, model_locked ? 32'h0 : 32'hDEADBEEF});
            @(posedge clk);
            #1;
        end
        bus.req_valid = 1'b0;
        if (model_locked && exp_cnt < 255) exp_cnt++;
        @(negedge clk);
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_idle", {bus.req_ready, bus.rsp_valid}, 2'b10);

        // Asynchronous reset while a faulted response is pending.
        bus.rsp_ready = 1'b0;
        issue(1'b0, 64'hBAD0ADD000000000, 32'h0, lat);
        if (exp_cnt < 255) exp_cnt++;
        chk("pre_rst_cnt", {56'd0, fault_cnt}, 64'(exp_cnt));
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out", {bus.rsp_valid, bus.rsp_fault, fault_cnt, locked}, 11'd0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_cnt = 0;
        model_locked = 1'b0;
        xact("rd_w1_rst", 1'b0, 64'hA219987200000004, 32'h0, 1'b1, 32'h0, 1'b1);

        for (int i = 0; i < 260; i++)
            xact("sat", 1'b0, 64'h00000000FFFFFFF0, 32'h0, 1'b0, 32'h0, 1'b0);
        chk("sat_cnt", {56'd0, fault_cnt}, 64'd255);
        chk("sat_locked", {63'd0, locked}, {63'd0, model_locked});
        xact("rd_w0_end", 1'b0, 64'hA219987200000000, 32'h0, 1'b1, 32'h0, 1'b1);
        chk("end_locked", {63'd0, locked}, {63'd0, model_locked});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
